mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 76 +++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between control_unit and mem_responder.
// The zero flag exists only when ZERO_FLAG_EN is defined.
interface mem_responder_if;
  logic       rd;
  logic       wr;
  logic [2:0] addr;
  logic [8:0] data_in;
  logic [8:0] data_out;
  logic       ack;
  logic       busy;
  logic       err;
`ifdef ZERO_FLAG_EN
  logic       zero;
`endif

  modport master (
    output rd, wr, addr, data_in,
`ifdef ZERO_FLAG_EN
    input  zero,
`endif
    input  data_out, ack, busy, err
  );

  modport slave (
    input  rd, wr, addr, data_in,
`ifdef ZERO_FLAG_EN
    output zero,
`endif
    output data_out, ack, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// 8 x 9-bit register file answering single rd/wr requests with an ack pulse.
// Optional ZERO_FLAG_EN adds a zero flag derived from the registered data_out.
module mem_responder (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);
  localparam int DEPTH = 8;
  localparam int DW    = 9;
  localparam int AW    = 3;

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  state_t                    state, state_nxt;
  req_t                      req_q, req_nxt;
  logic [DEPTH-1:0][DW-1:0]  mem;
  logic [DW-1:0]             data_out_q;
  logic                      ack_q;
  logic                      err_q, err_nxt;

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd && bus.wr) begin
          err_nxt = 1'b1;
        end else if (bus.rd) begin
          req_nxt.addr = bus.addr;
          state_nxt    = RD;
        end else if (bus.wr) begin
          req_nxt   = '{addr: bus.addr, data: bus.data_in};
          state_nxt = WR;
        end
      end
      RD, WR:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ack is registered off the ACK state, so it lands while the FSM is
  // already back in IDLE and the next request can be taken on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      mem        <= '0;
    end else begin
      state <= state_nxt;
      req_q <= req_nxt;
      err_q <= err_nxt;
      ack_q <= (state == ACK);
      if (state == RD) data_out_q <= mem[req_q.addr];
      if (state == WR) mem[req_q.addr] <= req_q.data;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state != IDLE);

`ifdef ZERO_FLAG_EN
  assign bus.zero = (data_out_q == '0);
`endif
endmodule
